// File: rtl/posit_addsub_sched.sv
// posit_addsub_sched: round-robin scheduler of two add/sub requesters onto one shared fixed-latency posit adder.
// Latency: accept in cycle t -> rspK_valid in cycle t+2+LAT (t+1 for zero-bypassed operations when enabled).
// Backpressure: each requester has one op in flight; reqK_ready stays low until its held response is consumed.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   reqK_valid/ready/a/b/sub (K=0,1) request channel; sub=1 computes a-b
//   rspK_valid/ready/res   (K=0,1)   per-requester response register
//   add_valid, add_a, add_b          registered operands to the shared adder
//   add_res                          adder result, valid LAT cycles after add_valid
// Optional feature: define POSIT_SCHED_ZERO_BYPASS_EN to answer ops with a zero
// operand directly from the scheduler, without using the adder.
module posit_addsub_sched #(
  parameter int N   = 32,
  parameter int ES  = 2,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req1_sub,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [N-1:0] rsp0_res,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp1_res,
  output logic         add_valid,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  input  logic [N-1:0] add_res
);

  // An illegal parameter set never grants, so a misconfigured instance stays inert.
  localparam bit CFG_OK = (LAT >= 1) && (N >= ES + 3);
  localparam int PL     = (LAT < 1) ? 1 : LAT;

  logic         busy0, busy1, ptr;
  logic         elig0, elig1, grant0, grant1, accept;
  logic [N-1:0] sel_a, sel_b, neg_b, byp_res;
  logic         sel_sub, byp;
  logic         issue_tag;
  logic [PL-1:0] pipe_vld, pipe_tag;
  logic         ret_vld, ret_tag;

  assign elig0 = req0_valid & ~busy0;
  assign elig1 = req1_valid & ~busy1;

  // ptr only matters on a tie; a lone eligible requester always wins.
  assign grant0 = CFG_OK & ~rst & elig0 & (~elig1 | ~ptr);
  assign grant1 = CFG_OK & ~rst & elig1 & ~grant0;
  assign accept = grant0 | grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign sel_a   = grant1 ? req1_a   : req0_a;
  assign sel_b   = grant1 ? req1_b   : req0_b;
  assign sel_sub = grant1 ? req1_sub : req0_sub;

  // Posit negation is plain two's complement; 0 and NaR map onto themselves.
  assign neg_b = sel_sub ? -sel_b : sel_b;

`ifdef POSIT_SCHED_ZERO_BYPASS_EN
  assign byp = (sel_a == '0) || (sel_b == '0);
`else
  assign byp = 1'b0;
`endif
  assign byp_res = (sel_a == '0) ? neg_b : sel_a;

  // The last stage lines up with add_res for the op issued LAT cycles earlier.
  assign ret_vld = pipe_vld[PL-1];
  assign ret_tag = pipe_tag[PL-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      busy0      <= 1'b0;
      busy1      <= 1'b0;
      ptr        <= 1'b0;
      add_valid  <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
      issue_tag  <= 1'b0;
      pipe_vld   <= '0;
      pipe_tag   <= '0;
      rsp0_valid <= 1'b0;
      rsp0_res   <= '0;
      rsp1_valid <= 1'b0;
      rsp1_res   <= '0;
    end else begin
      add_valid <= accept & ~byp;
      if (accept & ~byp) begin
        add_a     <= sel_a;
        add_b     <= neg_b;
        issue_tag <= grant1;
      end
      if (accept) ptr <= grant0;

      pipe_vld[0] <= add_valid;
      pipe_tag[0] <= issue_tag;
      for (int i = 1; i < PL; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end

      // Busy guarantees a requester's return and its next accept never collide.
      if (rsp0_valid & rsp0_ready) begin
        rsp0_valid <= 1'b0;
        busy0      <= 1'b0;
      end
      if (ret_vld & ~ret_tag) begin
        rsp0_valid <= 1'b1;
        rsp0_res   <= add_res;
      end
      if (grant0) begin
        busy0 <= 1'b1;
        if (byp) begin
          rsp0_valid <= 1'b1;
          rsp0_res   <= byp_res;
        end
      end

      if (rsp1_valid & rsp1_ready) begin
        rsp1_valid <= 1'b0;
        busy1      <= 1'b0;
      end
      if (ret_vld & ret_tag) begin
        rsp1_valid <= 1'b1;
        rsp1_res   <= add_res;
      end
      if (grant1) begin
        busy1 <= 1'b1;
        if (byp) begin
          rsp1_valid <= 1'b1;
          rsp1_res   <= byp_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_posit_addsub_sched.sv
// tb_posit_addsub_sched: scenario bench for the posit add/sub scheduler with a behavioural adder.
// Latency: the adder model answers LAT cycles after add_valid; accepts push expected results to queues.
// Backpressure: response ready is driven per scenario; a negedge monitor pops and compares on handshakes.
module tb_posit_addsub_sched;
  localparam int N   = 32;
  localparam int ES  = 2;
  localparam int LAT = 2;
`ifdef POSIT_SCHED_ZERO_BYPASS_EN
  localparam bit BYP_EN = 1'b1;
`else
  localparam bit BYP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_sub, req1_valid, req1_ready, req1_sub;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [N-1:0] rsp0_res, rsp1_res;
  logic         add_valid;
  logic [N-1:0] add_a, add_b, add_res;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] issue_q[$];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] res_line[0:LAT];
  logic [63:0] mon_op;
  logic [31:0] mon_res;

  always #5 clk = ~clk;

  posit_addsub_sched #(.N(N), .ES(ES), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(rsp0_res),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(rsp1_res),
    .add_valid(add_valid), .add_a(add_a), .add_b(add_b), .add_res(add_res)
  );

  // Behavioural adder: exact for zero operands and 1.0+1.0, an arbitrary mix otherwise.
  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h0) return b;
    if (b == 32'h0) return a;
    if (a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4800_0000;
    return (a + b) ^ 32'h0F0F_0000;
  endfunction

  task automatic note_accept(input int k, input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [31:0] b_eff;
    b_eff = sub ? (32'h0 - b) : b;
    if (!(BYP_EN && (a == 32'h0 || b == 32'h0))) issue_q.push_back({a, b_eff});
    if (k == 0) exp_q0.push_back(model_add(a, b_eff));
    else        exp_q1.push_back(model_add(a, b_eff));
  endtask

  // Adder model: result driven at the negedge LAT cycles after add_valid, junk otherwise.
  initial begin
    for (int i = 0; i <= LAT; i++) res_line[i] = 32'h0;
    add_res = 32'h0;
    forever begin
      @(negedge clk);
      for (int i = LAT; i > 0; i--) res_line[i] = res_line[i-1];
      res_line[0] = (add_valid === 1'b1) ? model_add(add_a, add_b) : $urandom();
      add_res = res_line[LAT];
    end
  end

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (add_valid === 1'b1) begin
        n_checks++;
        if (issue_q.size() == 0) begin
          n_fail++;
          $display("FAIL add_spurious: add_valid=1 got a=%h b=%h, required no issue", add_a, add_b);
        end else begin
          mon_op = issue_q.pop_front();
          if ({add_a, add_b} !== mon_op) begin
            n_fail++;
            $display("FAIL add_operands: got %h_%h required %h_%h", add_a, add_b, mon_op[63:32], mon_op[31:0]);
          end
        end
      end
      if (rsp0_valid === 1'b1 && rsp0_ready === 1'b1) begin
        n_checks++;
        mon_res = (exp_q0.size() != 0) ? exp_q0.pop_front() : 32'hxxxx_xxxx;
        if (rsp0_res !== mon_res) begin
          n_fail++;
          $display("FAIL rsp0_result: got %h required %h", rsp0_res, mon_res);
        end
      end
      if (rsp1_valid === 1'b1 && rsp1_ready === 1'b1) begin
        n_checks++;
        mon_res = (exp_q1.size() != 0) ? exp_q1.pop_front() : 32'hxxxx_xxxx;
        if (rsp1_res !== mon_res) begin
          n_fail++;
          $display("FAIL rsp1_result: got %h required %h", rsp1_res, mon_res);
        end
      end
      if (req0_valid === 1'b1 && req1_valid === 1'b1) begin
        n_checks++;
        if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
          n_fail++;
          $display("FAIL double_grant: got ready0=1 ready1=1 required at most one");
        end
      end
      if (req0_valid === 1'b1 && req0_ready === 1'b1) note_accept(0, req0_a, req0_b, req0_sub);
      if (req1_valid === 1'b1 && req1_ready === 1'b1) note_accept(1, req1_a, req1_b, req1_sub);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic [31:0] a, input logic [31:0] b, input logic sub);
    if (k == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_sub = sub;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_sub = sub;
    end
  endtask

  task automatic flush_queues();
    issue_q.delete();
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    flush_queues();
    tick();
    rst = 1'b0;
  endtask

  // Returns the cycle index (counted from the accept cycle) at which rspK_valid is seen, or -1.
  task automatic wait_rsp(input int k, input int start, output int lat);
    lat = -1;
    for (int i = start; i <= start + 40; i++) begin
      @(negedge clk);
      if ((k == 0 && rsp0_valid === 1'b1) || (k == 1 && rsp1_valid === 1'b1)) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (issue_q.size() == 0 && exp_q0.size() == 0 && exp_q1.size() == 0 &&
          rsp0_valid !== 1'b1 && rsp1_valid !== 1'b1) break;
    end
  endtask

  task automatic test_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b required 00", {req0_ready, req1_ready});
    end
    n_checks++;
    if ({rsp0_valid, rsp1_valid, add_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_valids: got %b required 000", {rsp0_valid, rsp1_valid, add_valid});
    end
    n_checks++;
    if ({rsp0_res, rsp1_res} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rsp_res: got %h_%h required 0", rsp0_res, rsp1_res);
    end
    n_checks++;
    if ({add_a, add_b} !== 64'h0) begin
      n_fail++; $display("FAIL reset_add_ops: got %h_%h required 0", add_a, add_b);
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    int lat;
    tick();
    set_req(0, 1'b1, 32'h4000_0000, 32'h4000_0000, 1'b0);
    @(negedge clk);
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_accept: got ready0=%b required 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({add_valid, add_a, add_b} !== {1'b1, 32'h4000_0000, 32'h4000_0000}) begin
      n_fail++; $display("FAIL single_issue: got v=%b a=%h b=%h required v=1 a=40000000 b=40000000", add_valid, add_a, add_b);
    end
    wait_rsp(0, 2, lat);
    n_checks++;
    if (lat != LAT + 2) begin
      n_fail++; $display("FAIL single_latency: got %0d required %0d", lat, LAT + 2);
    end
    n_checks++;
    if (rsp0_res !== 32'h4800_0000) begin
      n_fail++; $display("FAIL single_result: got %h required 48000000", rsp0_res);
    end
    tick();
  endtask

  task automatic test_sub_neg();
    logic [31:0] bv [2] = '{32'h4000_0000, 32'h8000_0000};
    logic [31:0] eb [2] = '{32'hC000_0000, 32'h8000_0000};
    int lat;
    for (int v = 0; v < 2; v++) begin
      tick();
      set_req(1, 1'b1, 32'h4800_0000, bv[v], 1'b1);
      @(negedge clk);
      n_checks++;
      if (req1_ready !== 1'b1) begin
        n_fail++; $display("FAIL sub_accept: got ready1=%b required 1", req1_ready);
      end
      tick();
      req1_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({add_valid, add_b} !== {1'b1, eb[v]}) begin
        n_fail++; $display("FAIL sub_negate: got v=%b b=%h required v=1 b=%h", add_valid, add_b, eb[v]);
      end
      wait_rsp(1, 2, lat);
      n_checks++;
      if (lat != LAT + 2) begin
        n_fail++; $display("FAIL sub_latency: got %0d required %0d", lat, LAT + 2);
      end
      tick();
    end
  endtask

  task automatic test_zero_operand();
    int          kv [2] = '{0, 1};
    logic [31:0] av [2] = '{32'h0000_0000, 32'h4800_0000};
    logic [31:0] bv [2] = '{32'h4800_0000, 32'h0000_0000};
    logic [31:0] ev [2] = '{32'hB800_0000, 32'h4800_0000};
    int lat;
    logic rv, gv;
    logic [31:0] res;
    for (int v = 0; v < 2; v++) begin
      tick();
      set_req(kv[v], 1'b1, av[v], bv[v], 1'b1);
      @(negedge clk);
      gv = (kv[v] == 0) ? req0_ready : req1_ready;
      n_checks++;
      if (gv !== 1'b1) begin
        n_fail++; $display("FAIL zero_accept: got ready=%b required 1", gv);
      end
      tick();
      set_req(kv[v], 1'b0, av[v], bv[v], 1'b1);
      @(negedge clk);
      n_checks++;
      if (add_valid !== (BYP_EN ? 1'b0 : 1'b1)) begin
        n_fail++; $display("FAIL zero_add_pulse: got %b required %b", add_valid, !BYP_EN);
      end
      rv = (kv[v] == 0) ? rsp0_valid : rsp1_valid;
      if (rv === 1'b1) lat = 1;
      else wait_rsp(kv[v], 2, lat);
      n_checks++;
      if (lat != (BYP_EN ? 1 : LAT + 2)) begin
        n_fail++; $display("FAIL zero_latency: got %0d required %0d", lat, BYP_EN ? 1 : LAT + 2);
      end
      res = (kv[v] == 0) ? rsp0_res : rsp1_res;
      n_checks++;
      if (res !== ev[v]) begin
        n_fail++; $display("FAIL zero_result: got %h required %h", res, ev[v]);
      end
      tick();
    end
  endtask

  task automatic test_contention();
    int lat, prev, idx, expi;
    logic g, eg;
    do_reset();
    tick();
    set_req(0, 1'b1, 32'h1234_0000, 32'h0567_0000, 1'b0);
    set_req(1, 1'b1, 32'h2222_0000, 32'h0111_0000, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL tie_first: got %b required 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++; $display("FAIL tie_second: got %b required 01", {req0_ready, req1_ready});
    end
    tick();
    req1_valid = 1'b0;
    wait_idle();
    tick();
    // A lone grant to requester 0 points the tie-break at requester 1.
    set_req(0, 1'b1, 32'h3000_0000, 32'h0100_0000, 1'b0);
    tick();
    req0_valid = 1'b0;
    wait_rsp(0, 1, lat);
    tick();
    set_req(0, 1'b1, 32'h3300_0000, 32'h0200_0000, 1'b0);
    set_req(1, 1'b1, 32'h5100_0000, 32'h0300_0000, 1'b1);
    prev = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      g  = req0_ready | req1_ready;
      eg = ((c % (LAT + 3)) < 2);
      n_checks++;
      if (g !== eg) begin
        n_fail++; $display("FAIL rr_grant_cycle: cycle %0d got grant=%b required %b", c, g, eg);
      end
      if (g === 1'b1) begin
        idx  = (req1_ready === 1'b1) ? 1 : 0;
        expi = (prev < 0) ? 1 : 1 - prev;
        n_checks++;
        if (idx != expi) begin
          n_fail++; $display("FAIL rr_order: cycle %0d got requester %0d required %0d", c, idx, expi);
        end
        prev = idx;
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
    n_checks++;
    if (issue_q.size() + exp_q0.size() + exp_q1.size() != 0) begin
      n_fail++; $display("FAIL contention_drain: got %0d pending required 0", issue_q.size() + exp_q0.size() + exp_q1.size());
    end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    tick();
    rsp0_ready = 1'b0;
    set_req(0, 1'b1, 32'h4000_0000, 32'h4000_0000, 1'b0);
    @(negedge clk);
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_accept: got ready0=%b required 1", req0_ready);
    end
    tick();
    set_req(0, 1'b1, 32'h4800_0000, 32'h4000_0000, 1'b0);
    wait_rsp(0, 1, lat);
    n_checks++;
    if (lat != LAT + 2) begin
      n_fail++; $display("FAIL bp_latency: got %0d required %0d", lat, LAT + 2);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if ({rsp0_valid, rsp0_res, req0_ready} !== {1'b1, 32'h4800_0000, 1'b0}) begin
        n_fail++; $display("FAIL bp_hold: cycle %0d got v=%b res=%h rdy=%b required v=1 res=48000000 rdy=0", c, rsp0_valid, rsp0_res, req0_ready);
      end
    end
    tick();
    rsp0_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_handshake_cycle: got ready0=%b required 0", req0_ready);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_reaccept: got ready0=%b required 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    wait_idle();
    n_checks++;
    if (issue_q.size() + exp_q0.size() + exp_q1.size() != 0) begin
      n_fail++; $display("FAIL bp_drain: got %0d pending required 0", issue_q.size() + exp_q0.size() + exp_q1.size());
    end
    tick();
  endtask

  task automatic test_reset_mid();
    tick();
    set_req(1, 1'b1, 32'h4000_0000, 32'h4000_0000, 1'b0);
    @(negedge clk);
    n_checks++;
    if (req1_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_accept: got ready1=%b required 1", req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    rst = 1'b1;
    tick();
    flush_queues();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if ({rsp0_valid, rsp1_valid, add_valid} !== 3'b000) begin
        n_fail++; $display("FAIL midrst_quiet: cycle %0d got %b required 000", c, {rsp0_valid, rsp1_valid, add_valid});
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready, rsp0_res, rsp1_res, add_a, add_b} !== 130'h0) begin
      n_fail++; $display("FAIL midrst_outputs: got rdy=%b%b res=%h_%h add=%h_%h required all 0", req0_ready, req1_ready, rsp0_res, rsp1_res, add_a, add_b);
    end
  endtask

  initial begin
    rst = 1'b1;
    set_req(0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_req(1, 1'b0, 32'h0, 32'h0, 1'b0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    test_reset();
    test_single_add();
    test_sub_neg();
    test_zero_operand();
    test_contention();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
